piece_ctr: RTL and testbench
============================

PIECE_CTR -- requirements
Module: piece_ctr

Interface
REQ-001 Parameter TICK, default 20000000: gravity period in clock cycles.
REQ-002 Parameter LOCK_CYCLES, default 20000000: hold time after landing, long enough for the board to latch the piece and clear lines.
REQ-003 Parameter CELL, default 40: cell pitch in pixels.
REQ-004 Parameter COLS, default 10: playfield columns.
REQ-005 Parameter SPAWN_COL, default 4: spawn column.
REQ-006 VGA_CLK_n  in  1  sole clock; all logic on rising edge.
REQ-007 iRST  in  1  reset, synchronous, active-high.
REQ-008 key_left, key_right, key_rot, key_drop  in  1 each  one-cycle pulses, already debounced and synchronized.
REQ-009 move_reset  in  1  board reports piece resting on stack or floor.
REQ-010 nl, nr  in  1 each  board reports a left/right neighbour is occupied.
REQ-011 lflag  in  1  board permits rotation.
REQ-012 line_clear  in  1  one-cycle pulse per cleared line.
REQ-013 xadd, yadd  out  10  piece origin in pixels, always a multiple of CELL.
REQ-014 x0,y0,x1,y1,x2,y2,x3,y3  out  2 each  cell offsets from the origin, in cells.
REQ-015 shape  out  3  piece type 0..4; direction  out  2  rotation state.
REQ-016 new_score  out  32  lines cleared; game_over  out  1.

Function
REQ-017 States: SPAWN, FALL, LOCK, OVER. Transition order: SPAWN->FALL after one cycle; FALL->LOCK; LOCK->SPAWN; SPAWN->OVER.
REQ-018 SPAWN shall set xadd=SPAWN_COL*CELL, yadd=0, direction=0, and shape=next_shape, then move to FALL.
REQ-019 Offsets are combinational from shape and direction, as (x,y) pairs for cells 0..3:
- square (0): every direction (0,0)(1,0)(0,1)(1,1).
- I (1): dir 0/2 (0,0)(1,0)(2,0)(3,0); dir 1/3 (0,0)(0,1)(0,2)(0,3).
- L (2): d0 (0,0)(0,1)(0,2)(1,2); d1 (0,0)(1,0)(2,0)(0,1); d2 (0,0)(1,0)(1,1)(1,2); d3 (2,0)(0,1)(1,1)(2,1).
- T (3): d0 (0,0)(1,0)(2,0)(1,1); d1 (1,0)(0,1)(1,1)(1,2); d2 (1,0)(0,1)(1,1)(2,1); d3 (0,0)(0,1)(1,1)(0,2).
- Z (4): d0/d2 (0,0)(1,0)(1,1)(2,1); d1/d3 (1,0)(0,1)(1,1)(0,2).
REQ-020 FALL gravity: a tick counter shall count 0..TICK-1; at TICK-1 it wraps to 0, and if move_reset=0 then yadd+=CELL, else the state goes to LOCK.
REQ-021 key_drop shall load the tick counter to TICK-1, so the gravity step occurs on the next cycle.
REQ-022 In FALL, key_left shall set xadd-=CELL when nl=0 and column>0; otherwise it is ignored.
REQ-023 In FALL, key_right shall set xadd+=CELL when nr=0 and column+max_x(current offsets)<COLS-1; otherwise it is ignored.
REQ-024 In FALL, key_rot shall set direction+=1 (mod 4) when lflag=1 and column+max_x(new offsets)<=COLS-1; otherwise it is ignored.
REQ-025 Same-cycle keys: key_rot has priority over key_left, which has priority over key_right; only one lateral or rotate action is applied per cycle.
REQ-026 A lateral or rotate action and a gravity step in the same cycle shall both be applied.
REQ-027 LOCK shall hold xadd, yadd, direction, and shape frozen for LOCK_CYCLES cycles, ignoring all keys, then go to SPAWN.
REQ-028 SPAWN->OVER: if move_reset=1 in the first FALL cycle after a spawn (yadd=0), the state shall go to OVER.
REQ-029 OVER shall set game_over=1, freeze all outputs, and remain until reset.
REQ-030 next_shape: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h5A) shall step every cycle; next_shape=lfsr[2:0] if that value is <5, else lfsr[2:0]-5.
REQ-031 new_score shall increment by 1 on each line_clear pulse in any state except OVER, saturating at 99 for two-digit display.
REQ-032 Arithmetic: the column is xadd/CELL, held as a registered cell index; xadd=column*CELL. No underflow or overflow is possible given REQ-022/023.

Reset
REQ-033 On iRST=1 at a clock edge, all of the following shall hold on the next cycle, including when reset arrives mid-LOCK or mid-FALL:
- state=SPAWN, tick and lock counters=0, lfsr=8'h5A.
- xadd=SPAWN_COL*CELL, yadd=0, shape=0, direction=0.
- new_score=0, game_over=0.

Verification (TICK=8, LOCK_CYCLES=4 in the bench)
REQ-034 Release reset, hold all inputs low: first shape=2 (lfsr 5A -> [2:0]=2), xadd=160; yadd steps 0->40->80 every 8 cycles.
REQ-035 key_left x5 with nl=0: xadd 160->0 after four presses; the fifth press is ignored and xadd stays 0.
REQ-036 I-bar at direction 0, column 6, key_right: rejected, xadd stays 240. With nr=1 at any column: rejected.
REQ-037 T piece, key_rot with lflag=0: direction unchanged. With lflag=1: direction 0->1, offsets (1,0)(0,1)(1,1)(1,2).
REQ-038 move_reset=1 at a tick: yadd frozen for 4 cycles, then the new shape spawns at yadd=0. move_reset=1 again in the first FALL cycle: game_over=1, and it stays 1 until iRST.
REQ-039 100 line_clear pulses: new_score=99. Assert iRST during LOCK: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/piece_ctr.sv
// Falling-piece controller: spawns LFSR-chosen pieces, applies gravity, moves, rotation and lock.
// Also keeps the saturating line score and the game-over flag.
module piece_ctr #(
  parameter int TICK        = 20000000,
  parameter int LOCK_CYCLES = 20000000,
  parameter int CELL        = 40,
  parameter int COLS        = 10,
  parameter int SPAWN_COL   = 4
) (
  input  logic        VGA_CLK_n,
  input  logic        iRST,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_rot,
  input  logic        key_drop,
  input  logic        move_reset,
  input  logic        nl,
  input  logic        nr,
  input  logic        lflag,
  input  logic        line_clear,
  output logic [9:0]  xadd,
  output logic [9:0]  yadd,
  output logic [1:0]  x0,
  output logic [1:0]  y0,
  output logic [1:0]  x1,
  output logic [1:0]  y1,
  output logic [1:0]  x2,
  output logic [1:0]  y2,
  output logic [1:0]  x3,
  output logic [1:0]  y3,
  output logic [2:0]  shape,
  output logic [1:0]  direction,
  output logic [31:0] new_score,
  output logic        game_over
);

  localparam logic [9:0]  CELL_W    = 10'(CELL);
  localparam logic [9:0]  SPAWN_W   = 10'(SPAWN_COL);
  localparam logic [9:0]  LAST_COL  = 10'(COLS - 1);
  localparam logic [31:0] TICK_LAST = 32'(TICK - 1);
  localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {SPAWN, FALL, LOCK, OVER} state_t;

  state_t      state, state_nxt;
  logic [31:0] tick_cnt, tick_nxt, lock_cnt, lock_nxt;
  logic [7:0]  lfsr, lfsr_nxt;
  logic [9:0]  col, col_nxt, ypos, ypos_nxt;
  logic [1:0]  dir, dir_nxt, dir_rot;
  logic [2:0]  shp, shp_nxt, next_shape;
  logic [31:0] score, score_nxt;
  logic        first, first_nxt;
  logic [15:0] cur_offs, rot_offs;
  logic        tick_top, rot_fit, right_fit;

  // Packed as {x0,y0,x1,y1,x2,y2,x3,y3}, two bits each.
  function automatic logic [15:0] offs(input logic [2:0] s, input logic [1:0] d);
    logic [15:0] o;
    o = 16'b0000_0100_0001_0101;
    case (s)
      3'd1: o = d[0] ? 16'b0000_0001_0010_0011 : 16'b0000_0100_1000_1100;
      3'd2: case (d)
              2'd0:    o = 16'b0000_0001_0010_0110;
              2'd1:    o = 16'b0000_0100_1000_0001;
              2'd2:    o = 16'b0000_0100_0101_0110;
              default: o = 16'b1000_0001_0101_1001;
            endcase
      3'd3: case (d)
              2'd0:    o = 16'b0000_0100_1000_0101;
              2'd1:    o = 16'b0100_0001_0101_0110;
              2'd2:    o = 16'b0100_0001_0101_1001;
              default: o = 16'b0000_0001_0101_0010;
            endcase
      3'd4: o = d[0] ? 16'b0100_0001_0101_0010 : 16'b0000_0100_0101_1001;
      default: o = 16'b0000_0100_0001_0101;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] max_x(input logic [15:0] o);
    logic [1:0] m;
    m = o[15:14];
    if (o[11:10] > m) m = o[11:10];
    if (o[7:6] > m)   m = o[7:6];
    if (o[3:2] > m)   m = o[3:2];
    return m;
  endfunction

  assign dir_rot    = dir + 2'd1;
  assign next_shape = (lfsr[2:0] < 3'd5) ? lfsr[2:0] : lfsr[2:0] - 3'd5;
  assign cur_offs   = offs(shp, dir);
  assign rot_offs   = offs(shp, dir_rot);
  assign tick_top   = (tick_cnt == TICK_LAST);
  assign rot_fit    = (col + {8'd0, max_x(rot_offs)}) <= LAST_COL;
  assign right_fit  = (col + {8'd0, max_x(cur_offs)}) < LAST_COL;

  assign {x0, y0, x1, y1, x2, y2, x3, y3} = cur_offs;
  assign xadd      = col * CELL_W;
  assign yadd      = ypos;
  assign shape     = shp;
  assign direction = dir;
  assign new_score = score;
  assign game_over = (state == OVER);

  always_ff @(posedge VGA_CLK_n) begin
    if (iRST) begin
      state    <= SPAWN;
      tick_cnt <= '0;
      lock_cnt <= '0;
      lfsr     <= 8'h5A;
      col      <= SPAWN_W;
      ypos     <= '0;
      dir      <= '0;
      shp      <= '0;
      score    <= '0;
      first    <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      lock_cnt <= lock_nxt;
      lfsr     <= lfsr_nxt;
      col      <= col_nxt;
      ypos     <= ypos_nxt;
      dir      <= dir_nxt;
      shp      <= shp_nxt;
      score    <= score_nxt;
      first    <= first_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    lock_nxt  = lock_cnt;
    col_nxt   = col;
    ypos_nxt  = ypos;
    dir_nxt   = dir;
    shp_nxt   = shp;
    first_nxt = first;
    lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    score_nxt = score;
    if (state != OVER && line_clear && score < 32'd99) score_nxt = score + 32'd1;

    case (state)
      SPAWN: begin
        col_nxt   = SPAWN_W;
        ypos_nxt  = '0;
        dir_nxt   = '0;
        shp_nxt   = next_shape;
        tick_nxt  = '0;
        lock_nxt  = '0;
        first_nxt = 1'b1;
        state_nxt = FALL;
      end
      FALL: begin
        first_nxt = 1'b0;
        // A piece that is already blocked right after spawning ends the game.
        if (first && move_reset) begin
          state_nxt = OVER;
        end else begin
          if (key_drop)      tick_nxt = TICK_LAST;
          else if (tick_top) tick_nxt = '0;
          else               tick_nxt = tick_cnt + 32'd1;
          if (tick_top) begin
            if (move_reset) begin
              state_nxt = LOCK;
              lock_nxt  = '0;
            end else begin
              ypos_nxt = ypos + CELL_W;
            end
          end
          if (key_rot) begin
            if (lflag && rot_fit) dir_nxt = dir_rot;
          end else if (key_left) begin
            if (!nl && col != '0) col_nxt = col - 10'd1;
          end else if (key_right) begin
            if (!nr && right_fit) col_nxt = col + 10'd1;
          end
        end
      end
      LOCK: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nxt = SPAWN;
          lock_nxt  = '0;
        end else begin
          lock_nxt = lock_cnt + 32'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piece_ctr.sv
// Bench for piece_ctr: per-cycle reference model comparison plus hand-computed literal checks.
module tb_piece_ctr;
  localparam int TICK = 8;
  localparam int LOCKC = 4;
  localparam int CELL = 40;
  localparam int COLS = 10;
  localparam int SPAWN_COL = 4;
  localparam int P_SPAWN = 0, P_FALL = 1, P_LOCK = 2, P_OVER = 3;
  localparam int K_LEFT = 1, K_RIGHT = 2, K_ROT = 4, K_DROP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_left = 0, key_right = 0, key_rot = 0, key_drop = 0;
  logic move_reset = 0, nl = 0, nr = 0, lflag = 0, line_clear = 0;
  logic [9:0] xadd, yadd;
  logic [1:0] x0, y0, x1, y1, x2, y2, x3, y3;
  logic [2:0] shape;
  logic [1:0] direction;
  logic [31:0] new_score;
  logic game_over;

  always #5 clk = ~clk;

  piece_ctr #(.TICK(TICK), .LOCK_CYCLES(LOCKC), .CELL(CELL), .COLS(COLS), .SPAWN_COL(SPAWN_COL)) dut (
    .VGA_CLK_n(clk), .iRST(rst),
    .key_left(key_left), .key_right(key_right), .key_rot(key_rot), .key_drop(key_drop),
    .move_reset(move_reset), .nl(nl), .nr(nr), .lflag(lflag), .line_clear(line_clear),
    .xadd(xadd), .yadd(yadd),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .shape(shape), .direction(direction), .new_score(new_score), .game_over(game_over)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Piece cells as x-list / y-list per shape and direction.
  function automatic int cell_coord(input int s, input int d, input int i, input bit want_y);
    int cx[4];
    int cy[4];
    cx = '{0, 1, 0, 1}; cy = '{0, 0, 1, 1};
    case (s)
      1: if (d % 2 == 0) begin cx = '{0, 1, 2, 3}; cy = '{0, 0, 0, 0}; end
         else            begin cx = '{0, 0, 0, 0}; cy = '{0, 1, 2, 3}; end
      2: case (d)
           0:       begin cx = '{0, 0, 0, 1}; cy = '{0, 1, 2, 2}; end
           1:       begin cx = '{0, 1, 2, 0}; cy = '{0, 0, 0, 1}; end
           2:       begin cx = '{0, 1, 1, 1}; cy = '{0, 0, 1, 2}; end
           default: begin cx = '{2, 0, 1, 2}; cy = '{0, 1, 1, 1}; end
         endcase
      3: case (d)
           0:       begin cx = '{0, 1, 2, 1}; cy = '{0, 0, 0, 1}; end
           1:       begin cx = '{1, 0, 1, 1}; cy = '{0, 1, 1, 2}; end
           2:       begin cx = '{1, 0, 1, 2}; cy = '{0, 1, 1, 1}; end
           default: begin cx = '{0, 0, 1, 0}; cy = '{0, 1, 1, 2}; end
         endcase
      4: if (d % 2 == 0) begin cx = '{0, 1, 1, 2}; cy = '{0, 0, 1, 1}; end
         else            begin cx = '{1, 0, 1, 0}; cy = '{0, 1, 1, 2}; end
      default: ;
    endcase
    return want_y ? cy[i] : cx[i];
  endfunction

  function automatic int width_of(input int s, input int d);
    int m = 0;
    for (int i = 0; i < 4; i++)
      if (cell_coord(s, d, i, 1'b0) > m) m = cell_coord(s, d, i, 1'b0);
    return m;
  endfunction

  function automatic logic [15:0] exp_offs(input int s, input int d);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[15 - 4*i -: 2] = 2'(cell_coord(s, d, i, 1'b0));
      r[13 - 4*i -: 2] = 2'(cell_coord(s, d, i, 1'b1));
    end
    return r;
  endfunction

  // Reference model state.
  int m_phase, m_col, m_row, m_dir, m_shape, m_grav, m_lockrem, m_lfsr, m_score;
  bit m_first;
  bit chk_en = 0;
  bit g;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_SPAWN; m_col = SPAWN_COL; m_row = 0; m_dir = 0; m_shape = 0;
      m_grav = TICK; m_lockrem = 0; m_lfsr = 'h5A; m_score = 0; m_first = 0;
    end else begin
      if (m_phase != P_OVER && line_clear && m_score < 99) m_score++;
      case (m_phase)
        P_SPAWN: begin
          m_shape = (m_lfsr % 8 < 5) ? m_lfsr % 8 : m_lfsr % 8 - 5;
          m_col = SPAWN_COL; m_row = 0; m_dir = 0; m_grav = TICK; m_first = 1;
          m_phase = P_FALL;
        end
        P_FALL: begin
          if (m_first && move_reset) begin
            m_phase = P_OVER;
          end else begin
            g = (m_grav == 1);
            m_grav = key_drop ? 1 : (g ? TICK : m_grav - 1);
            if (g) begin
              if (move_reset) begin m_phase = P_LOCK; m_lockrem = LOCKC; end
              else m_row++;
            end
            if (key_rot) begin
              if (lflag && m_col + width_of(m_shape, (m_dir + 1) % 4) <= COLS - 1) m_dir = (m_dir + 1) % 4;
            end else if (key_left) begin
              if (!nl && m_col > 0) m_col--;
            end else if (key_right) begin
              if (!nr && m_col + width_of(m_shape, m_dir) < COLS - 1) m_col++;
            end
          end
          m_first = 0;
        end
        P_LOCK: begin
          m_lockrem--;
          if (m_lockrem == 0) m_phase = P_SPAWN;
        end
        default: ;
      endcase
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("xadd", int'(xadd), (m_col * CELL) % 1024);
      check("yadd", int'(yadd), (m_row * CELL) % 1024);
      check("shape", int'(shape), m_shape);
      check("direction", int'(direction), m_dir);
      check("offsets", int'({x0, y0, x1, y1, x2, y2, x3, y3}), int'(exp_offs(m_shape, m_dir)));
      check("score", int'(new_score), m_score);
      check("game_over", int'(game_over), (m_phase == P_OVER) ? 1 : 0);
    end
  end

  // Called at a falling edge; holds the given keys for exactly one cycle.
  task automatic press(input int k);
    key_left  = (k & K_LEFT) != 0;
    key_right = (k & K_RIGHT) != 0;
    key_rot   = (k & K_ROT) != 0;
    key_drop  = (k & K_DROP) != 0;
    @(negedge clk);
    key_left = 0; key_right = 0; key_rot = 0; key_drop = 0;
  endtask

  // Hard-drop onto the stack, then wait through lock and spawn into the first fall cycle.
  task automatic land();
    press(K_DROP);
    move_reset = 1;
    @(negedge clk);
    move_reset = 0;
    repeat (LOCKC + 1) @(negedge clk);
  endtask

  task automatic land_until(input int target);
    int n = 0;
    do begin
      land();
      n++;
    end while (m_shape != target && n < 60);
    check("find_shape", int'(shape), target);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    check("rst_xadd", int'(xadd), 160);
    check("rst_yadd", int'(yadd), 0);
    check("rst_shape", int'(shape), 0);
    check("rst_go", int'(game_over), 0);
    rst = 0;
    @(negedge clk);
    check("first_shape", int'(shape), 2);
    check("first_xadd", int'(xadd), 160);
    repeat (7) @(negedge clk);
    check("grav_before", int'(yadd), 0);
    @(negedge clk);
    check("grav_1", int'(yadd), 40);
    repeat (8) @(negedge clk);
    check("grav_2", int'(yadd), 80);

    for (int i = 0; i < 5; i++) press(K_LEFT);
    check("left_edge", int'(xadd), 0);

    land_until(1);
    check("spawn_y", int'(yadd), 0);
    repeat (3) press(K_RIGHT);
    check("ibar_right_wall", int'(xadd), 240);

    land();
    nr = 1; press(K_RIGHT); nr = 0;
    check("nr_block", int'(xadd), 160);
    nl = 1; press(K_LEFT); nl = 0;
    check("nl_block", int'(xadd), 160);
    press(K_LEFT | K_RIGHT);
    check("left_over_right", int'(xadd), 120);

    land_until(3);
    lflag = 0; press(K_ROT);
    check("rot_no_lflag", int'(direction), 0);
    lflag = 1; press(K_ROT);
    check("rot_dir1", int'(direction), 1);
    check("t_d1_offs", int'({x0, y0, x1, y1, x2, y2, x3, y3}), int'(16'b0100_0001_0101_0110));
    press(K_ROT | K_LEFT);
    check("rot_over_left_dir", int'(direction), 2);
    check("rot_over_left_x", int'(xadd), 160);
    lflag = 0;

    line_clear = 1;
    repeat (100) @(negedge clk);
    line_clear = 0;
    check("score_sat", int'(new_score), 99);

    press(K_DROP);
    move_reset = 1;
    @(negedge clk);
    move_reset = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("lockrst_xadd", int'(xadd), 160);
    check("lockrst_yadd", int'(yadd), 0);
    check("lockrst_shape", int'(shape), 0);
    check("lockrst_dir", int'(direction), 0);
    check("lockrst_score", int'(new_score), 0);
    rst = 0;
    @(negedge clk);

    move_reset = 1;
    @(negedge clk);
    move_reset = 0;
    check("over_set", int'(game_over), 1);
    line_clear = 1; lflag = 1;
    press(K_LEFT); press(K_ROT); press(K_DROP);
    repeat (20) @(negedge clk);
    line_clear = 0; lflag = 0;
    check("over_hold", int'(game_over), 1);
    check("over_score", int'(new_score), 0);
    rst = 1;
    @(negedge clk);
    check("over_cleared", int'(game_over), 0);
    rst = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
